// File: rtl/taxi_pcie_us_rq_arb.sv
// Two-port PCIe requester-request (RQ) arbiter.
// Merges the read-DMA (port 0) and write-DMA (port 1) RQ TLP streams into one
// stream to the PCIe core. It arbitrates frame-by-frame with round-robin priority
// and has one output register stage. On each forwarded beat it writes the source
// port index into the MSB of every tuser sequence-number field. It routes
// sequence numbers returned by the core back to the port named by that MSB.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_axis_rq_0_*                 RQ sink, port 0 (read DMA)
//   s_axis_rq_1_*                 RQ sink, port 1 (write DMA)
//   m_axis_rq_*                   merged RQ source to the PCIe core
//   s_axis_rq_seq_num_{0,1}       sequence numbers returned by the core
//   s_axis_rq_seq_num_valid_{0,1} qualifiers for the returned numbers
//   m{0,1}_axis_rq_seq_num_{0,1}  returned numbers routed to port 0 / port 1
//   m{0,1}_axis_rq_seq_num_valid_{0,1}
module taxi_pcie_us_rq_arb #(
  parameter int unsigned AXIS_PCIE_DATA_W    = 256,
  parameter int unsigned AXIS_PCIE_KEEP_W    = AXIS_PCIE_DATA_W / 32,
  parameter int unsigned AXIS_PCIE_RQ_USER_W = 62,
  parameter int unsigned RQ_SEQ_NUM_W        = 6
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic [AXIS_PCIE_DATA_W-1:0]    s_axis_rq_0_tdata,
  input  logic [AXIS_PCIE_KEEP_W-1:0]    s_axis_rq_0_tkeep,
  input  logic                           s_axis_rq_0_tvalid,
  output logic                           s_axis_rq_0_tready,
  input  logic                           s_axis_rq_0_tlast,
  input  logic [AXIS_PCIE_RQ_USER_W-1:0] s_axis_rq_0_tuser,

  input  logic [AXIS_PCIE_DATA_W-1:0]    s_axis_rq_1_tdata,
  input  logic [AXIS_PCIE_KEEP_W-1:0]    s_axis_rq_1_tkeep,
  input  logic                           s_axis_rq_1_tvalid,
  output logic                           s_axis_rq_1_tready,
  input  logic                           s_axis_rq_1_tlast,
  input  logic [AXIS_PCIE_RQ_USER_W-1:0] s_axis_rq_1_tuser,

  output logic [AXIS_PCIE_DATA_W-1:0]    m_axis_rq_tdata,
  output logic [AXIS_PCIE_KEEP_W-1:0]    m_axis_rq_tkeep,
  output logic                           m_axis_rq_tvalid,
  input  logic                           m_axis_rq_tready,
  output logic                           m_axis_rq_tlast,
  output logic [AXIS_PCIE_RQ_USER_W-1:0] m_axis_rq_tuser,

  input  logic [RQ_SEQ_NUM_W-1:0]        s_axis_rq_seq_num_0,
  input  logic                           s_axis_rq_seq_num_valid_0,
  input  logic [RQ_SEQ_NUM_W-1:0]        s_axis_rq_seq_num_1,
  input  logic                           s_axis_rq_seq_num_valid_1,

  output logic [RQ_SEQ_NUM_W-1:0]        m0_axis_rq_seq_num_0,
  output logic                           m0_axis_rq_seq_num_valid_0,
  output logic [RQ_SEQ_NUM_W-1:0]        m0_axis_rq_seq_num_1,
  output logic                           m0_axis_rq_seq_num_valid_1,
  output logic [RQ_SEQ_NUM_W-1:0]        m1_axis_rq_seq_num_0,
  output logic                           m1_axis_rq_seq_num_valid_0,
  output logic [RQ_SEQ_NUM_W-1:0]        m1_axis_rq_seq_num_1,
  output logic                           m1_axis_rq_seq_num_valid_1
);

  // tuser bit that carries the MSB of each sequence-number field. The narrow
  // tuser has one field only, so the second position aliases the first.
  localparam int unsigned SEQ0_MSB_POS = (AXIS_PCIE_RQ_USER_W == 62) ?
                                         ((RQ_SEQ_NUM_W == 6) ? 61 : 27) :
                                         (61 + RQ_SEQ_NUM_W - 1);
  localparam int unsigned SEQ1_MSB_POS = (AXIS_PCIE_RQ_USER_W == 62) ?
                                         SEQ0_MSB_POS :
                                         (67 + RQ_SEQ_NUM_W - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                         r_state;
  logic                           r_sel;      // port owning the open frame
  logic                           r_rr_last;  // port granted most recently

  logic [AXIS_PCIE_DATA_W-1:0]    r_m_tdata;
  logic [AXIS_PCIE_KEEP_W-1:0]    r_m_tkeep;
  logic                           r_m_tvalid;
  logic                           r_m_tlast;
  logic [AXIS_PCIE_RQ_USER_W-1:0] r_m_tuser;

  logic [RQ_SEQ_NUM_W-1:0]        r_m0_seq_0;
  logic [RQ_SEQ_NUM_W-1:0]        r_m0_seq_1;
  logic [RQ_SEQ_NUM_W-1:0]        r_m1_seq_0;
  logic [RQ_SEQ_NUM_W-1:0]        r_m1_seq_1;
  logic                           r_m0_vld_0;
  logic                           r_m0_vld_1;
  logic                           r_m1_vld_0;
  logic                           r_m1_vld_1;

  logic                           w_out_ready;
  logic                           w_grant;
  logic                           w_grant_valid;
  logic                           w_xfer;
  logic [AXIS_PCIE_DATA_W-1:0]    w_data;
  logic [AXIS_PCIE_KEEP_W-1:0]    w_keep;
  logic                           w_last;
  logic [AXIS_PCIE_RQ_USER_W-1:0] w_user;
  logic                           w_ret_port_0;
  logic                           w_ret_port_1;
  logic [RQ_SEQ_NUM_W-1:0]        w_ret_val_0;
  logic [RQ_SEQ_NUM_W-1:0]        w_ret_val_1;

  // The output register can take a beat when it is empty or being drained.
  assign w_out_ready = !r_m_tvalid || m_axis_rq_tready;

  // Grant selection: hold the owner while locked, otherwise round-robin.
  always_comb begin
    w_grant = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_grant = r_sel;
    end else if (s_axis_rq_0_tvalid && s_axis_rq_1_tvalid) begin
      w_grant = ~r_rr_last;
    end else begin
      w_grant = s_axis_rq_1_tvalid;
    end
  end

  assign w_grant_valid = w_grant ? s_axis_rq_1_tvalid : s_axis_rq_0_tvalid;
  assign w_xfer        = w_grant_valid && w_out_ready;

  // Only the granted port sees tready; both ports are held off during reset.
  assign s_axis_rq_0_tready = !rst && w_out_ready && !w_grant;
  assign s_axis_rq_1_tready = !rst && w_out_ready &&  w_grant;

  // Beat mux. The sequence-number MSBs are overwritten with the source index.
  always_comb begin
    w_data = s_axis_rq_0_tdata;
    w_keep = s_axis_rq_0_tkeep;
    w_last = s_axis_rq_0_tlast;
    w_user = s_axis_rq_0_tuser;
    if (w_grant) begin
      w_data = s_axis_rq_1_tdata;
      w_keep = s_axis_rq_1_tkeep;
      w_last = s_axis_rq_1_tlast;
      w_user = s_axis_rq_1_tuser;
    end
    w_user[SEQ0_MSB_POS] = w_grant;
    w_user[SEQ1_MSB_POS] = w_grant;
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= '0;
    end else if (w_xfer) begin
      r_m_tdata  <= w_data;
      r_m_tkeep  <= w_keep;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_last;
      r_m_tuser  <= w_user;
    end else if (m_axis_rq_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Frame lock FSM. The round-robin pointer moves whenever a new frame starts,
  // and that includes single-beat frames that never leave IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_rr_last <= w_grant;
            r_sel     <= w_grant;
            if (!w_last) begin
              r_state <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The MSB of a returned number names its destination port and is cleared on delivery.
  assign w_ret_port_0 = s_axis_rq_seq_num_0[RQ_SEQ_NUM_W-1];
  assign w_ret_port_1 = s_axis_rq_seq_num_1[RQ_SEQ_NUM_W-1];
  assign w_ret_val_0  = {1'b0, s_axis_rq_seq_num_0[RQ_SEQ_NUM_W-2:0]};
  assign w_ret_val_1  = {1'b0, s_axis_rq_seq_num_1[RQ_SEQ_NUM_W-2:0]};

  // Each return channel is routed on its own, so two returns in one cycle never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0_seq_0 <= '0;
      r_m0_seq_1 <= '0;
      r_m1_seq_0 <= '0;
      r_m1_seq_1 <= '0;
      r_m0_vld_0 <= 1'b0;
      r_m0_vld_1 <= 1'b0;
      r_m1_vld_0 <= 1'b0;
      r_m1_vld_1 <= 1'b0;
    end else begin
      r_m0_vld_0 <= s_axis_rq_seq_num_valid_0 && !w_ret_port_0;
      r_m1_vld_0 <= s_axis_rq_seq_num_valid_0 &&  w_ret_port_0;
      r_m0_vld_1 <= s_axis_rq_seq_num_valid_1 && !w_ret_port_1;
      r_m1_vld_1 <= s_axis_rq_seq_num_valid_1 &&  w_ret_port_1;
      r_m0_seq_0 <= (s_axis_rq_seq_num_valid_0 && !w_ret_port_0) ? w_ret_val_0 : '0;
      r_m1_seq_0 <= (s_axis_rq_seq_num_valid_0 &&  w_ret_port_0) ? w_ret_val_0 : '0;
      r_m0_seq_1 <= (s_axis_rq_seq_num_valid_1 && !w_ret_port_1) ? w_ret_val_1 : '0;
      r_m1_seq_1 <= (s_axis_rq_seq_num_valid_1 &&  w_ret_port_1) ? w_ret_val_1 : '0;
    end
  end

  assign m_axis_rq_tdata  = r_m_tdata;
  assign m_axis_rq_tkeep  = r_m_tkeep;
  assign m_axis_rq_tvalid = r_m_tvalid;
  assign m_axis_rq_tlast  = r_m_tlast;
  assign m_axis_rq_tuser  = r_m_tuser;

  assign m0_axis_rq_seq_num_0       = r_m0_seq_0;
  assign m0_axis_rq_seq_num_valid_0 = r_m0_vld_0;
  assign m0_axis_rq_seq_num_1       = r_m0_seq_1;
  assign m0_axis_rq_seq_num_valid_1 = r_m0_vld_1;
  assign m1_axis_rq_seq_num_0       = r_m1_seq_0;
  assign m1_axis_rq_seq_num_valid_0 = r_m1_vld_0;
  assign m1_axis_rq_seq_num_1       = r_m1_seq_1;
  assign m1_axis_rq_seq_num_valid_1 = r_m1_vld_1;

endmodule

// File: doc/taxi_pcie_us_rq_arb.md
TAXI_PCIE_US_RQ_ARB -- requirements
Module: taxi_pcie_us_rq_arb

Interface
REQ-001 Parameter RQ_SEQ_NUM_W, default 6, is the width of the PCIe core RQ sequence number (4 or 6).
REQ-002 Parameter AXIS_PCIE_RQ_USER_W, default 62, is the RQ tuser width (62 or 137); it SHALL match all three taxi_axis_if instances.
REQ-003 Port clk, input, 1: the single clock for all logic.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port s_axis_rq_0, taxi_axis_if sink: RQ TLP stream from the read DMA engine (port 0).
REQ-006 Port s_axis_rq_1, taxi_axis_if sink: RQ TLP stream from the write DMA engine (port 1).
REQ-007 Port m_axis_rq, taxi_axis_if source: merged RQ stream to the PCIe core.
REQ-008 Ports s_axis_rq_seq_num_0/1, inputs, RQ_SEQ_NUM_W, plus s_axis_rq_seq_num_valid_0/1, inputs, 1: sequence numbers returned by the core.
REQ-009 Ports m0_axis_rq_seq_num_0/1 and m1_axis_rq_seq_num_0/1, outputs, RQ_SEQ_NUM_W, plus matching _valid_0/1 outputs, 1: returned sequence numbers routed to ports 0 and 1.

Function
REQ-010 Output SHALL be a single register stage: input beat accepted when !m_axis_rq.tvalid || m_axis_rq.tready; latency input-to-output exactly 1 cycle; full throughput of 1 beat/cycle.
REQ-011 Arbiter states: IDLE (no frame open) and LOCKED (frame in progress on granted port).
REQ-012 In IDLE, grant SHALL go to the only valid port; if both valid, to the port not granted last (round-robin); grant is made in the same cycle the first beat transfers.
REQ-013 IDLE->LOCKED when the granted first beat transfers with tlast=0; LOCKED->IDLE when a beat with tlast=1 transfers; a single-beat frame stays in IDLE and updates the round-robin pointer.
REQ-014 In LOCKED, only the granted port's tready may be asserted; the other port's tready SHALL be 0 regardless of its tvalid.
REQ-015 tdata, tkeep, tlast SHALL pass unmodified; tuser passes unmodified except the sequence-number fields.
REQ-016 Seq-number fields: USER_W 62 -> {tuser[61:60], tuser[27:24]} (6-bit) or tuser[27:24] (4-bit); USER_W 137 -> seq_num0 tuser[66:61] and seq_num1 tuser[72:67].
REQ-017 On every forwarded beat the MSB of each seq-number field SHALL be replaced with the source port index; sources use only the lower RQ_SEQ_NUM_W-1 bits.
REQ-018 Returned seq_num_N with valid_N SHALL appear on mP_axis_rq_seq_num_N (P = returned MSB) the next cycle with MSB cleared and valid asserted; the other port's valid_N SHALL be 0.
REQ-019 Both returns valid in one cycle SHALL be routed independently, including both to the same port on its _0 and _1 channels; no return is ever dropped or delayed beyond 1 cycle.
REQ-020 Straddled TLPs on USER_W 137 are not supported; inputs SHALL present at most one TLP start per beat.

Reset
REQ-021 While rst is high: m_axis_rq.tvalid=0, all s_axis tready=0, all seq-number outputs and valids=0, state=IDLE, round-robin pointer set so port 0 wins the first tie.
REQ-022 Reset asserted mid-frame SHALL discard the open frame and registered beat; after release arbitration restarts in IDLE with no partial frame emitted.

Verification
REQ-023 Both ports present 4-beat frames continuously, m_tready=1 -> output frames alternate 0,1,0,1 starting with port 0, 8 beats per 8 cycles, no interleaving.
REQ-024 Port 1 frame in progress (beat 2 of 5) when port 0 asserts tvalid -> port 0 tready stays 0 until port 1 tlast transfers, then port 0 is granted next cycle.
REQ-025 Port 0 sends seq 0x05, port 1 sends seq 0x05 (6-bit) -> m_axis_rq tuser seq fields 0x05 and 0x25; core returns 0x25 on _0 and 0x05 on _1 same cycle -> m1 _0 = 0x05 valid and m0 _1 = 0x05 valid one cycle later.
REQ-026 m_tready held 0 for 3 cycles with one beat registered -> tvalid and data held stable, both input treadys 0, no beat lost or duplicated.
REQ-027 rst pulsed during beat 3 of a 6-beat frame -> tvalid drops, outputs zero; new single-beat frames on both ports after release -> port 0 first, then port 1.
